// File: rtl/lane_game_pkg.sv
// Shared constants for the lane game controller: FSM encodings, default
// parameters, output widths and signed score saturation limits.
package lane_game_pkg;

    localparam int unsigned DEF_LANES      = 4;
    localparam int unsigned DEF_NOTES      = 128;
    localparam int unsigned DEF_HIT_CYCLES = 50_000_000;
    localparam int unsigned DEF_GAP_CYCLES = 25_000_000;
    localparam int unsigned DEF_SCORE_W    = 8;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned TARGET_W = 3;
    localparam int unsigned STREAK_W = 8;
    localparam int unsigned NOTES_W  = 10;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_PICK = 3'd1;
    localparam state_t ST_NOTE = 3'd2;
    localparam state_t ST_GAP  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    localparam logic [STREAK_W-1:0] STREAK_MAX = 8'hFF;

    // Largest and smallest values of a w-bit two's-complement score.
    function automatic int score_max(input int unsigned w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int score_min(input int unsigned w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/lane_press_detect.sv
// Per-lane two-flop synchroniser followed by a registered falling-edge detect
// on the active-low buttons; press_c pulses for one cycle per new press.
module lane_press_detect
    import lane_game_pkg::*;
#(
    parameter int unsigned LANES = DEF_LANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] buttons,
    output logic [LANES-1:0] press_c
);

    logic [LANES-1:0] sync1_q, sync1_d;
    logic [LANES-1:0] sync2_q, sync2_d;
    logic [LANES-1:0] prev_q,  prev_d;

    always_comb begin
        sync1_d = buttons;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Flops reset to the released level so reset release never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign press_c = prev_q & ~sync2_q;

endmodule

// File: rtl/lane_game_ctrl.sv
// Rhythm-game controller: picks a target lane per note, opens a timed hit
// window, scores hits/misses with saturation and sequences a whole song.
module lane_game_ctrl
    import lane_game_pkg::*;
#(
    parameter int unsigned LANES      = DEF_LANES,
    parameter int unsigned NOTES      = DEF_NOTES,
    parameter int unsigned HIT_CYCLES = DEF_HIT_CYCLES,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int unsigned SCORE_W    = DEF_SCORE_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LANES-1:0]          buttons,
    input  logic [15:0]               rand_in,
    output logic [TARGET_W-1:0]       target,
    output logic                      note_active,
    output logic signed [SCORE_W-1:0] score,
    output logic [STREAK_W-1:0]       streak,
    output logic [NOTES_W-1:0]        notes_left,
    output logic                      done
);

    localparam int unsigned TMR_MAX = (HIT_CYCLES > GAP_CYCLES) ? HIT_CYCLES : GAP_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] HIT_LOAD = TMR_W'(HIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

    localparam logic signed [SCORE_W-1:0] SCORE_HI = SCORE_W'(score_max(SCORE_W));
    localparam logic signed [SCORE_W-1:0] SCORE_LO = SCORE_W'(score_min(SCORE_W));

    state_t                      state_q,       state_d;
    logic [TMR_W-1:0]            tmr_q,         tmr_d;
    logic [TARGET_W-1:0]         target_q,      target_d;
    logic                        note_active_q, note_active_d;
    logic signed [SCORE_W-1:0]   score_q,       score_d;
    logic [STREAK_W-1:0]         streak_q,      streak_d;
    logic [NOTES_W-1:0]          notes_left_q,  notes_left_d;
    logic                        done_q,        done_d;

    logic [LANES-1:0] press_c;
    logic [LANES-1:0] target_mask_c;
    logic [15:0]      lane_pick_c;
    logic             any_press_c;
    logic             hit_c;

    lane_press_detect #(
        .LANES (LANES)
    ) u_press (
        .clk     (clk),
        .rst     (rst),
        .buttons (buttons),
        .press_c (press_c)
    );

    assign lane_pick_c   = rand_in % 16'(LANES);
    assign target_mask_c = LANES'(1) << target_q;
    assign any_press_c   = |press_c;
    // Exactly the target lane counts; any extra lane turns the press into a miss.
    assign hit_c         = (press_c == target_mask_c);

    // Next-state, shared timer and scoring.
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        target_d     = target_q;
        score_d      = score_q;
        streak_d     = streak_q;
        notes_left_d = notes_left_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_PICK;
                    tmr_d        = '0;
                    score_d      = '0;
                    streak_d     = '0;
                    notes_left_d = NOTES_W'(NOTES);
                end
            end
            ST_PICK: begin
                target_d     = TARGET_W'(lane_pick_c);
                notes_left_d = notes_left_q - NOTES_W'(1);
                tmr_d        = HIT_LOAD;
                state_d      = ST_NOTE;
            end
            ST_NOTE: begin
                // A press wins over a window expiring on the same edge.
                if (any_press_c || (tmr_q == '0)) begin
                    state_d = ST_GAP;
                    tmr_d   = GAP_LOAD;
                    if (any_press_c && hit_c) begin
                        score_d  = (score_q == SCORE_HI) ? score_q : score_q + SCORE_W'(1);
                        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
                    end else begin
                        score_d  = (score_q == SCORE_LO) ? score_q : score_q - SCORE_W'(1);
                        streak_d = '0;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (tmr_q == '0) begin
                    state_d = (notes_left_q != '0) ? ST_PICK : ST_DONE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase

        note_active_d = (state_d == ST_NOTE);
        done_d        = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            tmr_q         <= '0;
            target_q      <= '0;
            note_active_q <= 1'b0;
            score_q       <= '0;
            streak_q      <= '0;
            notes_left_q  <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            target_q      <= target_d;
            note_active_q <= note_active_d;
            score_q       <= score_d;
            streak_q      <= streak_d;
            notes_left_q  <= notes_left_d;
            done_q        <= done_d;
        end
    end

    assign target      = target_q;
    assign note_active = note_active_q;
    assign score       = score_q;
    assign streak      = streak_q;
    assign notes_left  = notes_left_q;
    assign done        = done_q;

endmodule

// File: tb/tb_lane_game_ctrl.sv
// Directed bench for lane_game_ctrl: a 3-note song instance and a 4-bit-score
// 10-note instance, driven and sampled on the falling clock edge.
module tb_lane_game_ctrl;

    localparam int ACT_A  = 0;
    localparam int DONE_A = 1;
    localparam int ACT_B  = 2;
    localparam int DONE_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [15:0] rand_in = 16'd6;

    logic              start_a = 1'b0;
    logic [3:0]        buttons_a = 4'hF;
    logic [2:0]        target_a;
    logic              note_active_a;
    logic signed [7:0] score_a;
    logic [7:0]        streak_a;
    logic [9:0]        notes_left_a;
    logic              done_a;

    logic              start_b = 1'b0;
    logic [3:0]        buttons_b = 4'hF;
    logic [2:0]        target_b;
    logic              note_active_b;
    logic signed [3:0] score_b;
    logic [7:0]        streak_b;
    logic [9:0]        notes_left_b;
    logic              done_b;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lane_game_ctrl #(
        .LANES(4), .NOTES(3), .HIT_CYCLES(20), .GAP_CYCLES(5), .SCORE_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .buttons(buttons_a), .rand_in(rand_in),
        .target(target_a), .note_active(note_active_a), .score(score_a),
        .streak(streak_a), .notes_left(notes_left_a), .done(done_a)
    );

    lane_game_ctrl #(
        .LANES(4), .NOTES(10), .HIT_CYCLES(20), .GAP_CYCLES(5), .SCORE_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .buttons(buttons_b), .rand_in(rand_in),
        .target(target_b), .note_active(note_active_b), .score(score_b),
        .streak(streak_b), .notes_left(notes_left_b), .done(done_b)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for a flag to go high; ok=0 if the budget runs out.
    task automatic wait_flag(input int sel, output bit ok);
        logic v;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            case (sel)
                ACT_A:   v = note_active_a;
                DONE_A:  v = done_a;
                ACT_B:   v = note_active_b;
                default: v = done_b;
            endcase
            if (v === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        tick(2);
        n_total++; if (target_a !== 3'd0) $display("FAIL reset_target: got %0d want 0", target_a); else n_pass++;
        n_total++; if (note_active_a !== 1'b0) $display("FAIL reset_note_active: got %0b want 0", note_active_a); else n_pass++;
        n_total++; if (score_a !== 8'sd0) $display("FAIL reset_score: got %0d want 0", score_a); else n_pass++;
        n_total++; if (streak_a !== 8'd0) $display("FAIL reset_streak: got %0d want 0", streak_a); else n_pass++;
        n_total++; if (notes_left_a !== 10'd0) $display("FAIL reset_notes_left: got %0d want 0", notes_left_a); else n_pass++;
        n_total++; if (done_a !== 1'b0) $display("FAIL reset_done: got %0b want 0", done_a); else n_pass++;
        rst = 1'b1;
        tick(1);
        n_total++; if (note_active_a !== 1'b0) $display("FAIL idle_no_start: got %0b want 0", note_active_a); else n_pass++;
    endtask

    task automatic test_hit();
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        n_total++; if (notes_left_a !== 10'd3) $display("FAIL start_load_notes: got %0d want 3", notes_left_a); else n_pass++;
        n_total++; if (note_active_a !== 1'b0) $display("FAIL pick_note_active: got %0b want 0", note_active_a); else n_pass++;
        tick(1);
        n_total++; if (target_a !== 3'd2) $display("FAIL pick_target: got %0d want 2", target_a); else n_pass++;
        n_total++; if (note_active_a !== 1'b1) $display("FAIL note_open: got %0b want 1", note_active_a); else n_pass++;
        n_total++; if (notes_left_a !== 10'd2) $display("FAIL pick_dec: got %0d want 2", notes_left_a); else n_pass++;
        buttons_a = 4'b1011;
        tick(2);
        n_total++; if (score_a !== 8'sd0) $display("FAIL hit_latency_early: got %0d want 0", score_a); else n_pass++;
        tick(1);
        n_total++; if (score_a !== 8'sd1) $display("FAIL hit_score: got %0d want 1", score_a); else n_pass++;
        n_total++; if (streak_a !== 8'd1) $display("FAIL hit_streak: got %0d want 1", streak_a); else n_pass++;
        n_total++; if (note_active_a !== 1'b0) $display("FAIL hit_to_gap: got %0b want 0", note_active_a); else n_pass++;
        buttons_a = 4'hF;
        tick(5);
        n_total++; if (note_active_a !== 1'b0) $display("FAIL gap_length: got %0b want 0", note_active_a); else n_pass++;
        tick(1);
        n_total++; if (note_active_a !== 1'b1) $display("FAIL gap_to_note: got %0b want 1", note_active_a); else n_pass++;
        n_total++; if (notes_left_a !== 10'd1) $display("FAIL second_pick_dec: got %0d want 1", notes_left_a); else n_pass++;
    endtask

    task automatic test_double_press();
        buttons_a = 4'b1010;
        tick(2);
        n_total++; if (score_a !== 8'sd1) $display("FAIL dbl_early: got %0d want 1", score_a); else n_pass++;
        tick(1);
        n_total++; if (score_a !== 8'sd0) $display("FAIL dbl_score: got %0d want 0", score_a); else n_pass++;
        n_total++; if (streak_a !== 8'd0) $display("FAIL dbl_streak: got %0d want 0", streak_a); else n_pass++;
        buttons_a = 4'hF;
        tick(4);
        n_total++; if (score_a !== 8'sd0) $display("FAIL dbl_single_update: got %0d want 0", score_a); else n_pass++;
    endtask

    task automatic test_done_hold();
        bit ok;
        wait_flag(DONE_A, ok);
        n_total++; if (!ok) $display("FAIL done_timeout: got no done want done=1"); else n_pass++;
        n_total++; if (score_a !== -8'sd1) $display("FAIL expire_score: got %0d want -1", score_a); else n_pass++;
        n_total++; if (notes_left_a !== 10'd0) $display("FAIL done_notes_left: got %0d want 0", notes_left_a); else n_pass++;
        n_total++; if (note_active_a !== 1'b0) $display("FAIL done_note_active: got %0b want 0", note_active_a); else n_pass++;
        buttons_a = 4'b1011;
        tick(5);
        n_total++; if (score_a !== -8'sd1) $display("FAIL done_hold_score: got %0d want -1", score_a); else n_pass++;
        n_total++; if (done_a !== 1'b1) $display("FAIL done_hold: got %0b want 1", done_a); else n_pass++;
        n_total++; if (target_a !== 3'd2) $display("FAIL done_hold_target: got %0d want 2", target_a); else n_pass++;
        buttons_a = 4'hF;
        tick(4);
    endtask

    task automatic test_restart_no_press();
        bit ok;
        int cnt;
        logic signed [7:0] exp_s;
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        n_total++; if (score_a !== 8'sd0) $display("FAIL restart_score: got %0d want 0", score_a); else n_pass++;
        n_total++; if (done_a !== 1'b0) $display("FAIL restart_done: got %0b want 0", done_a); else n_pass++;
        n_total++; if (notes_left_a !== 10'd3) $display("FAIL restart_load: got %0d want 3", notes_left_a); else n_pass++;
        tick(1);
        n_total++; if (notes_left_a !== 10'd2) $display("FAIL restart_pick: got %0d want 2", notes_left_a); else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            wait_flag(ACT_A, ok);
            n_total++; if (!ok) $display("FAIL window_open_%0d: got timeout want note_active=1", k); else n_pass++;
            cnt = 0;
            while (note_active_a === 1'b1 && cnt < 100) begin
                cnt++;
                @(negedge clk);
            end
            exp_s = 8'(-k);
            n_total++; if (cnt != 20) $display("FAIL window_len_%0d: got %0d want 20", k, cnt); else n_pass++;
            n_total++; if (score_a !== exp_s) $display("FAIL miss_score_%0d: got %0d want %0d", k, score_a, exp_s); else n_pass++;
        end
        wait_flag(DONE_A, ok);
        n_total++; if (!ok) $display("FAIL restart_done_timeout: got no done want done=1"); else n_pass++;
        n_total++; if (score_a !== -8'sd3) $display("FAIL all_miss_score: got %0d want -3", score_a); else n_pass++;
        n_total++; if (streak_a !== 8'd0) $display("FAIL all_miss_streak: got %0d want 0", streak_a); else n_pass++;
        n_total++; if (notes_left_a !== 10'd0) $display("FAIL all_miss_notes_left: got %0d want 0", notes_left_a); else n_pass++;
    endtask

    task automatic test_saturation();
        bit ok;
        logic signed [3:0] exp_s;
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            wait_flag(ACT_B, ok);
            n_total++; if (!ok) $display("FAIL sat_open_%0d: got timeout want note_active=1", i); else n_pass++;
            buttons_b = 4'b1011;
            tick(3);
            exp_s = 4'((i > 7) ? 7 : i);
            n_total++; if (score_b !== exp_s) $display("FAIL sat_score_%0d: got %0d want %0d", i, score_b, exp_s); else n_pass++;
            n_total++; if (streak_b !== 8'(i)) $display("FAIL sat_streak_%0d: got %0d want %0d", i, streak_b, i); else n_pass++;
            buttons_b = 4'hF;
            tick(1);
        end
        wait_flag(DONE_B, ok);
        n_total++; if (!ok) $display("FAIL sat_done_timeout: got no done want done=1"); else n_pass++;
        n_total++; if (notes_left_b !== 10'd0) $display("FAIL sat_notes_left: got %0d want 0", notes_left_b); else n_pass++;
    endtask

    task automatic test_reset_mid();
        start_a = 1'b1;
        tick(4);
        n_total++; if (notes_left_a !== 10'd2) $display("FAIL start_ignored: got %0d want 2", notes_left_a); else n_pass++;
        n_total++; if (note_active_a !== 1'b1) $display("FAIL mid_in_note: got %0b want 1", note_active_a); else n_pass++;
        start_a = 1'b0;
        buttons_a = 4'b1011;
        tick(1);
        rst = 1'b0;
        #1;
        n_total++; if (note_active_a !== 1'b0) $display("FAIL mid_rst_note_active: got %0b want 0", note_active_a); else n_pass++;
        n_total++; if (target_a !== 3'd0) $display("FAIL mid_rst_target: got %0d want 0", target_a); else n_pass++;
        n_total++; if (notes_left_a !== 10'd0) $display("FAIL mid_rst_notes_left: got %0d want 0", notes_left_a); else n_pass++;
        n_total++; if (score_b !== 4'sd0) $display("FAIL mid_rst_score_b: got %0d want 0", score_b); else n_pass++;
        n_total++; if (done_b !== 1'b0) $display("FAIL mid_rst_done_b: got %0b want 0", done_b); else n_pass++;
        tick(2);
        rst = 1'b1;
        tick(10);
        n_total++; if (score_a !== 8'sd0) $display("FAIL held_release_score: got %0d want 0", score_a); else n_pass++;
        n_total++; if (streak_a !== 8'd0) $display("FAIL held_release_streak: got %0d want 0", streak_a); else n_pass++;
        n_total++; if (note_active_a !== 1'b0) $display("FAIL held_release_idle: got %0b want 0", note_active_a); else n_pass++;
        n_total++; if (done_a !== 1'b0) $display("FAIL held_release_done: got %0b want 0", done_a); else n_pass++;
        buttons_a = 4'hF;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_hit();
        test_double_press();
        test_done_hold();
        test_restart_no_press();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
